decode_stage: RTL and testbench

- Pipelined, handshaked RV32I/RV64I decode stage; successor to the combinational-after-register decoder.
- Sits between fetch and execute. Accepts {instr, pc} via valid/ready and emits decoded fields via valid/ready.
- Adds XLEN generalisation, a 2-entry skid buffer for full-throughput backpressure, flush, and explicit illegal-instruction flagging.
- Uses single-priority decode: exactly one instr_id per instruction, no competing always blocks.

---
 rtl/decode_pkg.sv | 94 +++++++++
 rtl/decode_stage_comb.sv | 135 +++++++++++++
 rtl/decode_stage.sv | 137 +++++++++++++
 tb/tb_decode_stage.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_pkg.sv
`default_nettype none
// ============================================================================
// Module   : decode_pkg
// Brief    : Shared RV32I/RV64I opcodes, instruction IDs, immediate formats
//            and the decoded-field struct used by the decode stage.
// Revision : 1.0 - initial release
// ============================================================================
package decode_pkg;

    localparam logic [6:0] OPC_LOAD   = 7'h03;
    localparam logic [6:0] OPC_OP_IMM = 7'h13;
    localparam logic [6:0] OPC_JALR   = 7'h67;
    localparam logic [6:0] OPC_SYSTEM = 7'h73;
    localparam logic [6:0] OPC_LUI    = 7'h37;
    localparam logic [6:0] OPC_AUIPC  = 7'h17;
    localparam logic [6:0] OPC_JAL    = 7'h6F;
    localparam logic [6:0] OPC_BRANCH = 7'h63;
    localparam logic [6:0] OPC_STORE  = 7'h23;
    localparam logic [6:0] OPC_OP     = 7'h33;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    localparam int ID_LUI    = 0;
    localparam int ID_AUIPC  = 1;
    localparam int ID_JAL    = 2;
    localparam int ID_JALR   = 3;
    localparam int ID_BEQ    = 4;
    localparam int ID_BNE    = 5;
    localparam int ID_BLT    = 6;
    localparam int ID_BGE    = 7;
    localparam int ID_BLTU   = 8;
    localparam int ID_BGEU   = 9;
    localparam int ID_LB     = 10;
    localparam int ID_LH     = 11;
    localparam int ID_LW     = 12;
    localparam int ID_LBU    = 13;
    localparam int ID_LHU    = 14;
    localparam int ID_SB     = 15;
    localparam int ID_SH     = 16;
    localparam int ID_SW     = 17;
    localparam int ID_ADDI   = 18;
    localparam int ID_SLTI   = 19;
    localparam int ID_SLTIU  = 20;
    localparam int ID_XORI   = 21;
    localparam int ID_ORI    = 22;
    localparam int ID_ANDI   = 23;
    localparam int ID_SLLI   = 24;
    localparam int ID_SRLI   = 25;
    localparam int ID_SRAI   = 26;
    localparam int ID_ADD    = 27;
    localparam int ID_SUB    = 28;
    localparam int ID_SLL    = 29;
    localparam int ID_SLT    = 30;
    localparam int ID_SLTU   = 31;
    localparam int ID_XOR    = 32;
    localparam int ID_SRL    = 33;
    localparam int ID_SRA    = 34;
    localparam int ID_OR     = 35;
    localparam int ID_AND    = 36;
    localparam int ID_ECALL  = 37;
    localparam int ID_EBREAK = 38;
    localparam int ID_LD     = 39;
    localparam int ID_LWU    = 40;
    localparam int ID_SD     = 41;
    localparam int ID_ILLEGAL = 63;

    typedef enum logic [2:0] {FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_R} imm_fmt_e;

    typedef struct packed {
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic [4:0] rd;
        logic [2:0] func3;
        logic [6:0] func7;
        logic [5:0] shamt;
        logic       illegal;
    } dec_fields_t;

    function automatic imm_fmt_e fmt_of(input logic [6:0] opc);
        imm_fmt_e f;
        case (opc)
            OPC_LOAD, OPC_OP_IMM, OPC_JALR, OPC_SYSTEM: f = FMT_I;
            OPC_STORE:                                 f = FMT_S;
            OPC_BRANCH:                                f = FMT_B;
            OPC_LUI, OPC_AUIPC:                        f = FMT_U;
            OPC_JAL:                                   f = FMT_J;
            default:                                   f = FMT_R;
        endcase
        return f;
    endfunction

endpackage
`default_nettype wire

// File: rtl/decode_stage_comb.sv
`default_nettype none
// ============================================================================
// Module   : decode_comb
// Brief    : Purely combinational instruction decoder: fields, immediate,
//            instruction ID and illegal flag, parametrised by XLEN.
// Revision : 1.0 - initial release
// ============================================================================
module decode_comb
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ID_W = 6
) (
    input  logic [31:0]     i_instr,
    output dec_fields_t     o_fields,
    output logic [XLEN-1:0] o_imm,
    output logic [ID_W-1:0] o_id
);

    localparam logic [ID_W-1:0] c_ID_ILLEGAL = {ID_W{1'b1}};
    localparam bit              c_RV64       = (XLEN == 64);

    logic [6:0]      w_opc;
    logic [2:0]      w_f3;
    logic            w_alt;
    logic            w_shamt_ok;
    logic [31:0]     w_imm32;
    logic [ID_W-1:0] w_id;

    assign w_opc      = i_instr[6:0];
    assign w_f3       = i_instr[14:12];
    assign w_alt      = i_instr[30];
    assign w_shamt_ok = c_RV64 || !i_instr[25];

    always_comb begin
        w_id = c_ID_ILLEGAL;
        if (i_instr == INSTR_ECALL) begin
            w_id = ID_W'(ID_ECALL);
        end else if (i_instr == INSTR_EBREAK) begin
            w_id = ID_W'(ID_EBREAK);
        end else begin
            case (w_opc)
                OPC_LUI:   w_id = ID_W'(ID_LUI);
                OPC_AUIPC: w_id = ID_W'(ID_AUIPC);
                OPC_JAL:   w_id = ID_W'(ID_JAL);
                OPC_JALR:  if (w_f3 == 3'b000) w_id = ID_W'(ID_JALR);
                OPC_BRANCH: begin
                    case (w_f3)
                        3'b000:  w_id = ID_W'(ID_BEQ);
                        3'b001:  w_id = ID_W'(ID_BNE);
                        3'b100:  w_id = ID_W'(ID_BLT);
                        3'b101:  w_id = ID_W'(ID_BGE);
                        3'b110:  w_id = ID_W'(ID_BLTU);
                        3'b111:  w_id = ID_W'(ID_BGEU);
                        default: w_id = c_ID_ILLEGAL;
                    endcase
                end
                OPC_LOAD: begin
                    case (w_f3)
                        3'b000:  w_id = ID_W'(ID_LB);
                        3'b001:  w_id = ID_W'(ID_LH);
                        3'b010:  w_id = ID_W'(ID_LW);
                        3'b100:  w_id = ID_W'(ID_LBU);
                        3'b101:  w_id = ID_W'(ID_LHU);
                        3'b011:  if (c_RV64) w_id = ID_W'(ID_LD);
                        3'b110:  if (c_RV64) w_id = ID_W'(ID_LWU);
                        default: w_id = c_ID_ILLEGAL;
                    endcase
                end
                OPC_STORE: begin
                    case (w_f3)
                        3'b000:  w_id = ID_W'(ID_SB);
                        3'b001:  w_id = ID_W'(ID_SH);
                        3'b010:  w_id = ID_W'(ID_SW);
                        3'b011:  if (c_RV64) w_id = ID_W'(ID_SD);
                        default: w_id = c_ID_ILLEGAL;
                    endcase
                end
                OPC_OP_IMM: begin
                    case (w_f3)
                        3'b000:  w_id = ID_W'(ID_ADDI);
                        3'b010:  w_id = ID_W'(ID_SLTI);
                        3'b011:  w_id = ID_W'(ID_SLTIU);
                        3'b100:  w_id = ID_W'(ID_XORI);
                        3'b110:  w_id = ID_W'(ID_ORI);
                        3'b111:  w_id = ID_W'(ID_ANDI);
                        3'b001:  if (w_shamt_ok) w_id = ID_W'(ID_SLLI);
                        default: if (w_shamt_ok) w_id = w_alt ? ID_W'(ID_SRAI) : ID_W'(ID_SRLI);
                    endcase
                end
                OPC_OP: begin
                    case (w_f3)
                        3'b000:  w_id = w_alt ? ID_W'(ID_SUB) : ID_W'(ID_ADD);
                        3'b001:  w_id = ID_W'(ID_SLL);
                        3'b010:  w_id = ID_W'(ID_SLT);
                        3'b011:  w_id = ID_W'(ID_SLTU);
                        3'b100:  w_id = ID_W'(ID_XOR);
                        3'b101:  w_id = w_alt ? ID_W'(ID_SRA) : ID_W'(ID_SRL);
                        3'b110:  w_id = ID_W'(ID_OR);
                        default: w_id = ID_W'(ID_AND);
                    endcase
                end
                default: w_id = c_ID_ILLEGAL;
            endcase
        end
    end

    // Immediates are assembled at 32 bits, then sign-extended to XLEN
    always_comb begin
        w_imm32 = '0;
        case (fmt_of(w_opc))
            FMT_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            FMT_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            FMT_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                                i_instr[30:25], i_instr[11:8], 1'b0};
            FMT_U:   w_imm32 = {i_instr[31:12], 12'b0};
            FMT_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                                i_instr[20], i_instr[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm32));
    assign o_id  = w_id;

    assign o_fields.rs1     = i_instr[19:15];
    assign o_fields.rs2     = i_instr[24:20];
    assign o_fields.rd      = i_instr[11:7];
    assign o_fields.func3   = w_f3;
    assign o_fields.func7   = i_instr[31:25];
    assign o_fields.shamt   = i_instr[25:20];
    assign o_fields.illegal = (w_id == c_ID_ILLEGAL);

endmodule
`default_nettype wire

// File: rtl/decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : decode_stage
// Brief    : Handshaked decode stage with main + skid entry registers and
//            flush. Optional perf counters under DECODE_STAGE_PERF_EN.
// Revision : 1.0 - initial release
// ============================================================================
module decode_stage
    import decode_pkg::*;
#(
    parameter int XLEN = 32,
    parameter int ID_W = 6
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     in_instr,
    input  logic [XLEN-1:0] in_pc,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [4:0]      rs1,
    output logic [4:0]      rs2,
    output logic [4:0]      rd,
    output logic [2:0]      func3,
    output logic [6:0]      func7,
    output logic [5:0]      shamt,
    output logic [XLEN-1:0] imm,
    output logic [ID_W-1:0] instr_id,
    output logic            illegal
`ifdef DECODE_STAGE_PERF_EN
    ,
    output logic [63:0]     perf_decoded,
    output logic [63:0]     perf_stall
`endif
);

    typedef struct packed {
        dec_fields_t     f;
        logic [XLEN-1:0] imm;
        logic [ID_W-1:0] id;
        logic [XLEN-1:0] pc;
    } entry_t;

    localparam entry_t c_ENTRY_RST = '{f: '0, imm: '0, id: {ID_W{1'b1}}, pc: '0};

    dec_fields_t     w_fields;
    logic [XLEN-1:0] w_imm;
    logic [ID_W-1:0] w_id;
    entry_t          w_new;
    entry_t          r_main;
    entry_t          r_skid;
    logic            r_main_v;
    logic            r_skid_v;
    logic            w_in_xfer;
    logic            w_out_xfer;

    decode_comb #(
        .XLEN (XLEN),
        .ID_W (ID_W)
    ) u_decode_comb (
        .i_instr  (in_instr),
        .o_fields (w_fields),
        .o_imm    (w_imm),
        .o_id     (w_id)
    );

    assign w_new      = '{f: w_fields, imm: w_imm, id: w_id, pc: in_pc};
    assign w_in_xfer  = in_valid && !r_skid_v;
    assign w_out_xfer = r_main_v && out_ready;

    // Skid can only hold an entry while main is full, so main always drains first
    always_ff @(posedge clk) begin
        if (rst) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
            r_main   <= c_ENTRY_RST;
            r_skid   <= c_ENTRY_RST;
        end else if (flush) begin
            r_main_v <= 1'b0;
            r_skid_v <= 1'b0;
        end else if (!r_main_v || w_out_xfer) begin
            if (r_skid_v) begin
                r_main   <= r_skid;
                r_main_v <= 1'b1;
                r_skid_v <= 1'b0;
            end else begin
                r_main_v <= w_in_xfer;
                if (w_in_xfer) begin
                    r_main <= w_new;
                end
            end
        end else if (w_in_xfer) begin
            r_skid   <= w_new;
            r_skid_v <= 1'b1;
        end
    end

    assign in_ready  = !r_skid_v;
    assign out_valid = r_main_v;
    assign out_pc    = r_main.pc;
    assign rs1       = r_main.f.rs1;
    assign rs2       = r_main.f.rs2;
    assign rd        = r_main.f.rd;
    assign func3     = r_main.f.func3;
    assign func7     = r_main.f.func7;
    assign shamt     = r_main.f.shamt;
    assign imm       = r_main.imm;
    assign instr_id  = r_main.id;
    assign illegal   = r_main.f.illegal;

`ifdef DECODE_STAGE_PERF_EN
    logic [63:0] r_perf_decoded;
    logic [63:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_decoded <= '0;
            r_perf_stall   <= '0;
        end else begin
            if (w_out_xfer) begin
                r_perf_decoded <= r_perf_decoded + 64'd1;
            end
            if (r_main_v && !out_ready) begin
                r_perf_stall <= r_perf_stall + 64'd1;
            end
        end
    end

    assign perf_decoded = r_perf_decoded;
    assign perf_stall   = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_decode_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_decode_stage
// Brief    : Self-checking bench driving XLEN=32 and XLEN=64 decode stages in
//            lockstep against a queue-based reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decode_stage;
    import decode_pkg::*;

    logic        clk = 1'b0;
    logic        rst, flush, in_valid, out_ready;
    logic [31:0] in_instr;
    logic [63:0] in_pc;

    logic        a_in_ready, a_out_valid, a_ill;
    logic [31:0] a_pc, a_imm;
    logic [4:0]  a_rs1, a_rs2, a_rd;
    logic [2:0]  a_f3;
    logic [6:0]  a_f7;
    logic [5:0]  a_sh, a_id;

    logic        b_in_ready, b_out_valid, b_ill;
    logic [63:0] b_pc, b_imm;
    logic [4:0]  b_rs1, b_rs2, b_rd;
    logic [2:0]  b_f3;
    logic [6:0]  b_f7;
    logic [5:0]  b_sh, b_id;

    always #5 clk = ~clk;

    decode_stage #(.XLEN(32), .ID_W(6)) u_dut32 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(a_in_ready),
        .in_instr(in_instr), .in_pc(in_pc[31:0]), .out_valid(a_out_valid), .out_ready(out_ready),
        .out_pc(a_pc), .rs1(a_rs1), .rs2(a_rs2), .rd(a_rd), .func3(a_f3), .func7(a_f7),
        .shamt(a_sh), .imm(a_imm), .instr_id(a_id), .illegal(a_ill)
    );

    decode_stage #(.XLEN(64), .ID_W(6)) u_dut64 (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(b_in_ready),
        .in_instr(in_instr), .in_pc(in_pc), .out_valid(b_out_valid), .out_ready(out_ready),
        .out_pc(b_pc), .rs1(b_rs1), .rs2(b_rs2), .rd(b_rd), .func3(b_f3), .func7(b_f7),
        .shamt(b_sh), .imm(b_imm), .instr_id(b_id), .illegal(b_ill)
    );

    typedef struct {
        logic [31:0] instr;
        logic [63:0] pc;
    } ent_t;

    ent_t q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Reference decoder: immediates computed as signed arithmetic values
    function automatic void ref_dec(input logic [31:0] ins, input int xl,
                                    output int id, output bit ill, output longint imm);
        logic [6:0] op;
        logic [2:0] f3;
        bit         alt, sh_ok;
        longint     s;
        op    = ins[6:0];
        f3    = ins[14:12];
        alt   = ins[30];
        sh_ok = (xl == 64) || !ins[25];
        s     = ins[31] ? 1 : 0;
        id    = -1;
        if (ins == 32'h0000_0073) id = ID_ECALL;
        else if (ins == 32'h0010_0073) id = ID_EBREAK;
        else begin
            case (op)
                7'h37: id = ID_LUI;
                7'h17: id = ID_AUIPC;
                7'h6F: id = ID_JAL;
                7'h67: if (f3 == 3'd0) id = ID_JALR;
                7'h63: begin
                    case (f3)
                        3'd0: id = ID_BEQ;   3'd1: id = ID_BNE;
                        3'd4: id = ID_BLT;   3'd5: id = ID_BGE;
                        3'd6: id = ID_BLTU;  3'd7: id = ID_BGEU;
                        default: id = -1;
                    endcase
                end
                7'h03: begin
                    case (f3)
                        3'd0: id = ID_LB;    3'd1: id = ID_LH;   3'd2: id = ID_LW;
                        3'd4: id = ID_LBU;   3'd5: id = ID_LHU;
                        3'd3: id = (xl == 64) ? ID_LD : -1;
                        3'd6: id = (xl == 64) ? ID_LWU : -1;
                        default: id = -1;
                    endcase
                end
                7'h23: begin
                    case (f3)
                        3'd0: id = ID_SB;    3'd1: id = ID_SH;   3'd2: id = ID_SW;
                        3'd3: id = (xl == 64) ? ID_SD : -1;
                        default: id = -1;
                    endcase
                end
                7'h13: begin
                    case (f3)
                        3'd0: id = ID_ADDI;  3'd2: id = ID_SLTI;  3'd3: id = ID_SLTIU;
                        3'd4: id = ID_XORI;  3'd6: id = ID_ORI;   3'd7: id = ID_ANDI;
                        3'd1: id = sh_ok ? ID_SLLI : -1;
                        default: id = !sh_ok ? -1 : (alt ? ID_SRAI : ID_SRLI);
                    endcase
                end
                7'h33: begin
                    case (f3)
                        3'd0: id = alt ? ID_SUB : ID_ADD;
                        3'd1: id = ID_SLL;   3'd2: id = ID_SLT;  3'd3: id = ID_SLTU;
                        3'd4: id = ID_XOR;   3'd6: id = ID_OR;   3'd7: id = ID_AND;
                        default: id = alt ? ID_SRA : ID_SRL;
                    endcase
                end
                default: id = -1;
            endcase
        end
        ill = (id < 0);
        if (ill) id = 63;
        case (op)
            7'h03, 7'h13, 7'h67, 7'h73: imm = longint'(ins[30:20]) - s * 2048;
            7'h23: imm = longint'({ins[30:25], ins[11:7]}) - s * 2048;
            7'h63: imm = longint'({ins[7], ins[30:25], ins[11:8], 1'b0}) - s * 4096;
            7'h37, 7'h17: imm = longint'({ins[30:12], 12'h000}) - s * (longint'(1) << 31);
            7'h6F: imm = longint'({ins[19:12], ins[20], ins[30:21], 1'b0}) - s * (longint'(1) << 20);
            default: imm = 0;
        endcase
    endfunction

    task automatic check_head(input string dut, input int xl, input logic [63:0] pc_g,
                              input logic [63:0] imm_g, input logic [4:0] rd_g,
                              input logic [4:0] rs1_g, input logic [4:0] rs2_g,
                              input logic [2:0] f3_g, input logic [6:0] f7_g,
                              input logic [5:0] sh_g, input logic [5:0] id_g, input logic ill_g);
        int          id;
        bit          ill;
        longint      imm;
        logic [63:0] m;
        logic [31:0] ins;
        ins = q[0].instr;
        ref_dec(ins, xl, id, ill, imm);
        m = (xl == 64) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'h0000_0000_FFFF_FFFF;
        chk({dut, ".rd"},  rd_g,  ins[11:7]);
        chk({dut, ".rs1"}, rs1_g, ins[19:15]);
        chk({dut, ".rs2"}, rs2_g, ins[24:20]);
        chk({dut, ".f3"},  f3_g,  ins[14:12]);
        chk({dut, ".f7"},  f7_g,  ins[31:25]);
        chk({dut, ".sh"},  sh_g,  ins[25:20]);
        chk({dut, ".pc"},  pc_g,  q[0].pc & m);
        chk({dut, ".imm"}, imm_g, imm & m);
        chk({dut, ".id"},  id_g,  id);
        chk({dut, ".ill"}, ill_g, ill);
    endtask

    task automatic check_all();
        chk("x32.out_valid", a_out_valid, q.size() > 0);
        chk("x64.out_valid", b_out_valid, q.size() > 0);
        chk("x32.in_ready",  a_in_ready,  q.size() < 2);
        chk("x64.in_ready",  b_in_ready,  q.size() < 2);
        if (q.size() > 0) begin
            check_head("x32", 32, {32'h0, a_pc}, {32'h0, a_imm}, a_rd, a_rs1, a_rs2,
                       a_f3, a_f7, a_sh, a_id, a_ill);
            check_head("x64", 64, b_pc, b_imm, b_rd, b_rs1, b_rs2,
                       b_f3, b_f7, b_sh, b_id, b_ill);
        end
    endtask

    task automatic check_reset_data();
        chk("rst.id32",  a_id,  63);
        chk("rst.id64",  b_id,  63);
        chk("rst.ill32", a_ill, 0);
        chk("rst.imm64", b_imm, 0);
        chk("rst.pc64",  b_pc,  0);
        chk("rst.rd32",  a_rd,  0);
        chk("rst.f7_64", b_f7,  0);
    endtask

    // Drive one cycle from a negedge, advance the FIFO model, then check at the next negedge
    task automatic cycle(input bit iv, input logic [31:0] ins, input bit ordy,
                         input bit fl, input bit rs);
        bit inx, outx;
        rst       = rs;
        flush     = fl;
        in_valid  = iv;
        in_instr  = ins;
        in_pc     = {$urandom, $urandom};
        out_ready = ordy;
        inx  = iv && (q.size() < 2);
        outx = (q.size() > 0) && ordy;
        if (rs || fl) begin
            q.delete();
        end else begin
            if (outx) void'(q.pop_front());
            if (inx) q.push_back('{instr: ins, pc: in_pc});
        end
        @(posedge clk);
        @(negedge clk);
        check_all();
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opc [10] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h37,
                                  7'h17, 7'h6F, 7'h63, 7'h23, 7'h33};
        logic [31:0] r;
        int          sel;
        r   = $urandom;
        sel = $urandom_range(0, 15);
        if (sel < 10) r[6:0] = opc[sel];
        else if (sel == 10) r = 32'h0000_0073;
        else if (sel == 11) r = 32'h0010_0073;
        return r;
    endfunction

    localparam logic [31:0] c_A = 32'h0010_0113;
    localparam logic [31:0] c_B = 32'h0020_81B3;
    localparam logic [31:0] c_C = 32'h4020_8233;

    initial begin
        rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_instr = '0; in_pc = '0;
        cycle(0, 32'h0, 1, 0, 1);
        cycle(0, 32'h0, 1, 0, 1);
        check_reset_data();

        cycle(1, 32'h0050_0093, 1, 0, 0);
        chk("addi.id", a_id, ID_ADDI);
        chk("addi.rd", a_rd, 1);
        chk("addi.rs1", a_rs1, 0);
        chk("addi.imm", a_imm, 5);
        chk("addi.ill", a_ill, 0);
        cycle(1, 32'h1234_5137, 1, 0, 0);
        chk("lui.imm64", b_imm, 64'h0000_0000_1234_5000);
        cycle(1, 32'h8000_0137, 1, 0, 0);
        chk("lui_neg.imm64", b_imm, 64'hFFFF_FFFF_8000_0000);
        chk("lui_neg.imm32", a_imm, 32'h8000_0000);
        cycle(1, 32'hFE00_0CE3, 1, 0, 0);
        chk("beq.id", a_id, ID_BEQ);
        chk("beq.imm32", a_imm, 32'hFFFF_FFF8);
        chk("beq.imm64", b_imm, 64'hFFFF_FFFF_FFFF_FFF8);
        cycle(1, 32'h0010_0073, 1, 0, 0);
        chk("ebreak.id", a_id, ID_EBREAK);
        cycle(1, 32'h0000_0073, 1, 0, 0);
        chk("ecall.id", b_id, ID_ECALL);
        cycle(1, 32'hFFFF_FFFF, 1, 0, 0);
        chk("allones.ill", a_ill, 1);
        chk("allones.id", a_id, 63);
        cycle(1, 32'h0200_9093, 1, 0, 0);
        chk("slli32.ill", a_ill, 1);
        chk("slli32.id", a_id, 63);
        chk("slli64.ill", b_ill, 0);
        chk("slli64.sh", b_sh, 32);
        chk("slli64.id", b_id, ID_SLLI);
        cycle(0, 32'h0, 1, 0, 0);

        // Backpressure: A, B fill both entries, C waits upstream
        cycle(1, c_A, 0, 0, 0);
        cycle(1, c_B, 0, 0, 0);
        chk("bp.in_ready", a_in_ready, 0);
        for (int i = 0; i < 3; i++) begin
            cycle(1, c_C, 0, 0, 0);
            chk("bp.hold_id", a_id, ID_ADDI);
        end
        cycle(1, c_C, 1, 0, 0);
        chk("bp.second", a_id, ID_ADD);
        cycle(1, c_C, 1, 0, 0);
        chk("bp.third", a_id, ID_SUB);
        chk("bp.no_bubble", a_out_valid, 1);
        cycle(0, 32'h0, 1, 0, 0);

        // Flush with both entries full, then with only main full
        cycle(1, c_A, 0, 0, 0);
        cycle(1, c_B, 0, 0, 0);
        cycle(1, c_C, 0, 1, 0);
        chk("flush.out_valid", a_out_valid, 0);
        chk("flush.in_ready", b_in_ready, 1);
        cycle(1, c_A, 0, 0, 0);
        cycle(1, c_C, 1, 1, 0);
        cycle(0, 32'h0, 1, 0, 0);
        chk("flush.dropped", b_out_valid, 0);

        // Reset mid-stream clears data outputs too
        cycle(1, c_C, 0, 0, 0);
        cycle(1, c_B, 0, 0, 1);
        check_reset_data();

        for (int i = 0; i < 3000; i++) begin
            cycle($urandom_range(0, 3) != 0, rand_instr(), $urandom_range(0, 3) != 0,
                  $urandom_range(0, 39) == 0, $urandom_range(0, 199) == 0);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
